mem_arbiter: RTL and testbench

Arbiter and sequencer that shares one single-ported, variable-latency unified memory between the pipeline's instruction-fetch port and its data-memory port. Services one access at a time through a req/ack handshake to the backing memory, returns read data with a one-cycle ready pulse, and drives a freeze signal that stalls PC, IF/ID and the later stage registers while any access is outstanding. It sits between the pipeline's IF/MEM stages and the memory model, replacing the separate instruction and data memories.

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_arbiter_watchdog.sv | 33 +++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the unified-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arbiter_pkg;

    localparam int DEF_WORD    = 32;  // data/address width
    localparam int DEF_TIMEOUT = 16;  // cycles to wait for mem_ack before aborting

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // sample requests, data port first
        ST_DACC = 2'd1,  // data access outstanding on the backing memory
        ST_IACC = 2'd2,  // fetch access outstanding on the backing memory
        ST_RESP = 2'd3   // one-cycle ready pulse to the owning port
    } state_t;

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// Access timeout counter: counts access cycles without an ack, flags expiry.
// Latency: expire is combinational in the TIMEOUT-th counted cycle.
// Backpressure: none; clear has priority over enable.
// Ports: clk, reset (async active-low), clear, enable in; expire out.
module mem_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    // The count holds the number of earlier unacked cycles, so the cycle that
    // sees TIMEOUT-1 already counted is the TIMEOUT-th one without an ack.
    assign expire = enable && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expire) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported variable-latency memory between fetch and data ports.
// Latency: request in IDLE cycle 0, mem_req cycles 1..k (ack at k), ready pulse k+1.
// Backpressure: freeze stalls the pipeline while any port request lacks its ready.
// Ports: if_* fetch port, dm_* data port, mem_* backing memory req/ack,
//        freeze pipeline stall, err sticky timeout flag; clk, reset (async active-low).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WORD    = DEF_WORD,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic            clk,
    input  logic            reset,
    // fetch port
    input  logic            if_req,
    input  logic [WORD-1:0] if_addr,
    output logic [WORD-1:0] if_rdata,
    output logic            if_ready,
    // data port
    input  logic            dm_read,
    input  logic            dm_write,
    input  logic [WORD-1:0] dm_addr,
    input  logic [WORD-1:0] dm_wdata,
    output logic [WORD-1:0] dm_rdata,
    output logic            dm_ready,
    // pipeline stall
    output logic            freeze,
    // backing memory
    output logic            mem_req,
    output logic            mem_we,
    output logic [WORD-1:0] mem_addr,
    output logic [WORD-1:0] mem_wdata,
    input  logic [WORD-1:0] mem_rdata,
    input  logic            mem_ack,
    // status
    output logic            err
);

    state_t          state;
    state_t          state_nxt;
    logic            own_dm;     // current/last access belongs to the data port
    logic            we_q;
    logic [WORD-1:0] addr_q;
    logic [WORD-1:0] wdata_q;
    logic            dm_any;
    logic            access;
    logic            expire;

    assign dm_any = dm_read | dm_write;
    assign access = (state == ST_DACC) || (state == ST_IACC);

    mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == ST_IDLE),
        .enable (access && !mem_ack),
        .expire (expire)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                // Data wins: it belongs to the older instruction in the pipe.
                if (dm_any) begin
                    state_nxt = ST_DACC;
                end else if (if_req) begin
                    state_nxt = ST_IACC;
                end
            end
            ST_DACC, ST_IACC: begin
                if (mem_ack || expire) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            own_dm   <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            if_rdata <= '0;
            dm_rdata <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;

            // Latch the winning request so the memory sees stable values even
            // though the pipeline is free to change its inputs.
            if (state == ST_IDLE) begin
                if (dm_any) begin
                    own_dm  <= 1'b1;
                    we_q    <= dm_write;  // read+write together acts as a write
                    addr_q  <= dm_addr;
                    wdata_q <= dm_wdata;
                end else if (if_req) begin
                    own_dm  <= 1'b0;
                    we_q    <= 1'b0;
                    addr_q  <= if_addr;
                end
            end

            if (access) begin
                if (mem_ack) begin
                    if (!own_dm) begin
                        if_rdata <= mem_rdata;
                    end else if (!we_q) begin
                        dm_rdata <= mem_rdata;
                    end
                end else if (expire) begin
                    err <= 1'b1;
                    if (own_dm) begin
                        dm_rdata <= '0;
                    end else begin
                        if_rdata <= '0;
                    end
                end
            end
        end
    end

    assign mem_req   = access;
    assign mem_we    = access && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign if_ready  = (state == ST_RESP) && !own_dm;
    assign dm_ready  = (state == ST_RESP) && own_dm;

    assign freeze    = (if_req && !if_ready) || (dm_any && !dm_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_read;
    logic        dm_write;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        freeze;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        err;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(
        .WORD    (32),
        .TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .dm_read   (dm_read),
        .dm_write  (dm_write),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .freeze    (freeze),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Advance into the next cycle, leaving room to drive inputs mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after input changes.
    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_read   = 1'b0;
        dm_write  = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;

        // ---------------- reset state ----------------
        tick();
        settle();
        check("rst_mem_req",  {31'd0, mem_req},  32'd0);
        check("rst_mem_we",   {31'd0, mem_we},   32'd0);
        check("rst_mem_addr", mem_addr,          32'd0);
        check("rst_wdata",    mem_wdata,         32'd0);
        check("rst_if_rdata", if_rdata,          32'd0);
        check("rst_dm_rdata", dm_rdata,          32'd0);
        check("rst_ready",    {30'd0, if_ready, dm_ready}, 32'd0);
        check("rst_err",      {31'd0, err},      32'd0);
        check("rst_freeze",   {31'd0, freeze},   32'd0);
        reset = 1'b1;
        tick();

        // ---------------- fetch only, ack in cycle 3 ----------------
        if_req  = 1'b1;                  // cycle 0
        if_addr = 32'h0000_0040;
        settle();
        check("f_c0_freeze",  {31'd0, freeze},  32'd1);
        check("f_c0_mem_req", {31'd0, mem_req}, 32'd0);
        tick();                          // cycle 1
        check("f_c1_mem_req", {31'd0, mem_req}, 32'd1);
        check("f_c1_addr",    mem_addr,         32'h0000_0040);
        check("f_c1_we",      {31'd0, mem_we},  32'd0);
        tick();                          // cycle 2
        check("f_c2_mem_req", {31'd0, mem_req}, 32'd1);
        check("f_c2_ready",   {31'd0, if_ready}, 32'd0);
        tick();                          // cycle 3
        mem_ack   = 1'b1;
        mem_rdata = 32'h2002_0005;
        settle();
        check("f_c3_mem_req", {31'd0, mem_req}, 32'd1);
        tick();                          // cycle 4
        mem_ack = 1'b0;
        settle();
        check("f_c4_ready",   {31'd0, if_ready}, 32'd1);
        check("f_c4_rdata",   if_rdata,          32'h2002_0005);
        check("f_c4_freeze",  {31'd0, freeze},   32'd0);
        check("f_c4_mem_req", {31'd0, mem_req},  32'd0);
        check("f_c4_dmready", {31'd0, dm_ready}, 32'd0);
        tick();                          // pipeline advanced
        if_req = 1'b0;
        settle();
        check("f_c5_ready",   {31'd0, if_ready}, 32'd0);
        check("f_c5_mem_req", {31'd0, mem_req},  32'd0);

        // ---------------- mem_ack while idle is ignored ----------------
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        tick();
        mem_ack = 1'b0;
        settle();
        check("idle_ack_ready", {30'd0, if_ready, dm_ready}, 32'd0);
        check("idle_ack_rdata", if_rdata, 32'h2002_0005);

        // ---------------- simultaneous data read + fetch ----------------
        dm_read = 1'b1;                  // cycle 0
        dm_addr = 32'h0000_0100;
        if_req  = 1'b1;
        if_addr = 32'h0000_0044;
        settle();
        check("b_c0_freeze", {31'd0, freeze}, 32'd1);
        tick();                          // cycle 1: data granted first
        check("b_c1_mem_req", {31'd0, mem_req}, 32'd1);
        check("b_c1_addr",    mem_addr,         32'h0000_0100);
        check("b_c1_we",      {31'd0, mem_we},  32'd0);
        check("b_c1_freeze",  {31'd0, freeze},  32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_2222;
        tick();                          // cycle 2
        mem_ack = 1'b0;
        settle();
        check("b_c2_dm_ready", {31'd0, dm_ready}, 32'd1);
        check("b_c2_dm_rdata", dm_rdata,          32'h1111_2222);
        check("b_c2_if_ready", {31'd0, if_ready}, 32'd0);
        check("b_c2_freeze",   {31'd0, freeze},   32'd1);
        tick();                          // cycle 3: IDLE, fetch sampled
        dm_read = 1'b0;
        settle();
        check("b_c3_dm_ready", {31'd0, dm_ready}, 32'd0);
        check("b_c3_mem_req",  {31'd0, mem_req},  32'd0);
        check("b_c3_freeze",   {31'd0, freeze},   32'd1);
        tick();                          // cycle 4
        check("b_c4_mem_req", {31'd0, mem_req}, 32'd1);
        check("b_c4_addr",    mem_addr,         32'h0000_0044);
        check("b_c4_freeze",  {31'd0, freeze},  32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h3333_4444;
        tick();                          // cycle 5
        mem_ack = 1'b0;
        settle();
        check("b_c5_if_ready", {31'd0, if_ready}, 32'd1);
        check("b_c5_if_rdata", if_rdata,          32'h3333_4444);
        check("b_c5_dm_rdata", dm_rdata,          32'h1111_2222);
        check("b_c5_freeze",   {31'd0, freeze},   32'd0);
        tick();
        if_req = 1'b0;

        // ---------------- data write ----------------
        dm_write = 1'b1;                 // cycle 0
        dm_addr  = 32'h0000_0200;
        dm_wdata = 32'hDEAD_BEEF;
        tick();                          // cycle 1
        check("w_c1_mem_req", {31'd0, mem_req}, 32'd1);
        check("w_c1_we",      {31'd0, mem_we},  32'd1);
        check("w_c1_addr",    mem_addr,         32'h0000_0200);
        check("w_c1_wdata",   mem_wdata,        32'hDEAD_BEEF);
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        tick();                          // cycle 2
        mem_ack = 1'b0;
        settle();
        check("w_c2_dm_ready", {31'd0, dm_ready}, 32'd1);
        check("w_c2_dm_rdata", dm_rdata,          32'h1111_2222);
        check("w_c2_we",       {31'd0, mem_we},   32'd0);
        tick();
        dm_write = 1'b0;

        // ---------------- timeout abort ----------------
        dm_read = 1'b1;                  // cycle 0
        dm_addr = 32'h0000_0300;
        for (int i = 1; i <= 16; i++) begin
            tick();                      // cycles 1..16, never acked
            check("t_mem_req", {31'd0, mem_req}, 32'd1);
        end
        check("t_c16_err", {31'd0, err}, 32'd0);
        tick();                          // cycle 17
        check("t_c17_mem_req",  {31'd0, mem_req},  32'd0);
        check("t_c17_dm_ready", {31'd0, dm_ready}, 32'd1);
        check("t_c17_dm_rdata", dm_rdata,          32'd0);
        check("t_c17_err",      {31'd0, err},      32'd1);
        tick();
        dm_read = 1'b0;
        settle();
        check("t_err_sticky", {31'd0, err}, 32'd1);
        // next request is serviced normally
        if_req  = 1'b1;
        if_addr = 32'h0000_0048;
        tick();
        check("t_next_addr", mem_addr, 32'h0000_0048);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_ack = 1'b0;
        settle();
        check("t_next_ready", {31'd0, if_ready}, 32'd1);
        check("t_next_rdata", if_rdata,          32'hCAFE_F00D);
        check("t_next_err",   {31'd0, err},      32'd1);
        tick();
        if_req = 1'b0;

        // ---------------- reset during a data access ----------------
        dm_read = 1'b1;
        dm_addr = 32'h0000_0400;
        tick();                          // cycle 1: DACC
        check("r_c1_mem_req", {31'd0, mem_req}, 32'd1);
        #2;
        reset   = 1'b0;                  // mid-cycle, asynchronous
        dm_read = 1'b0;
        settle();
        check("r_mem_req",  {31'd0, mem_req}, 32'd0);
        check("r_mem_addr", mem_addr,         32'd0);
        check("r_err",      {31'd0, err},     32'd0);
        check("r_if_rdata", if_rdata,         32'd0);
        check("r_dm_rdata", dm_rdata,         32'd0);
        tick();
        check("r_no_ready", {30'd0, if_ready, dm_ready}, 32'd0);
        reset = 1'b1;
        tick();
        if_req  = 1'b1;                  // clean fetch after release
        if_addr = 32'h0000_004C;
        tick();                          // cycle 1
        check("r_f_addr", mem_addr, 32'h0000_004C);
        tick();                          // cycle 2
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        tick();                          // cycle 3
        mem_ack = 1'b0;
        settle();
        check("r_f_ready",    {31'd0, if_ready}, 32'd1);
        check("r_f_rdata",    if_rdata,          32'h0BAD_F00D);
        check("r_f_dm_ready", {31'd0, dm_ready}, 32'd0);
        tick();
        if_req = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
